mul: RTL
========

MUL -- requirements
Module: mul

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Ports SHALL be exactly as follows (clock and reset first):
- clk   input   1  system clock, rising-edge active
- rst   input   1  asynchronous reset, active-low
- ld    input   1  1 = load operands; 0 = run
- a     input   4  multiplicand, unsigned
- b     input   4  multiplier, unsigned
- ra    output  8  accumulator (partial product); final product when done=1
- rb    output  8  shifted multiplicand register
- ry    output  4  remaining multiplier bits
- cnt   output  3  completed step count, 0..4
- done  output  1  1 = product valid in ra

Function
REQ-003 The block SHALL be a registered shift-and-add multiplier with states IDLE, RUN and DONE; all outputs are driven directly from registers.
REQ-004 On a rising edge with ld=1, in any state, the block SHALL load ra=0, rb={4'h0,a}, ry=b, cnt=0, done=0 and enter RUN.
- ld has priority over every other transition.
REQ-005 On a rising edge in RUN with ld=0, the block SHALL perform one step:
- if ry[0]=1: ra=ra+rb (8-bit add, never overflows for 4x4 operands)
- rb=rb<<1
- ry=ry>>1 (zero fill)
- cnt=cnt+1
REQ-006 On the edge that raises cnt from 3 to 4, the block SHALL enter DONE and set done=1; the result is ra=a*b, 4 edges after the load edge.
REQ-007 In DONE with ld=0, the block SHALL hold ra, rb, ry, cnt and done=1 indefinitely.
REQ-008 In IDLE with ld=0, the block SHALL hold all registers.
REQ-009 Operand changes on a and b while ld=0 SHALL have no effect.
REQ-010 ld held at 1 for multiple edges SHALL reload on every edge; stepping begins on the first edge with ld=0.
REQ-011 The block SHALL tolerate clk being a manually generated pulse; no timing assumption beyond single-edge behaviour.

Reset
REQ-012 When rst=0, independent of clk, the block SHALL immediately force ra=0, rb=0, ry=0, cnt=0, done=0 and state IDLE.
REQ-013 Reset asserted mid-RUN SHALL abort the operation; after reset release the block SHALL stay in IDLE until ld=1.
REQ-014 An edge coincident with reset release SHALL not be treated as a load or step.

Configuration
REQ-015 Macro MUL_EARLY_EXIT_EN SHALL control early termination.
- Defined: on an edge in RUN with ld=0 and ry=0, the block SHALL enter DONE with done=1, leave ra, rb and ry unchanged, and leave cnt at its current value.
- Not defined: every operation takes exactly 4 steps and DONE always shows cnt=4.
REQ-016 The final ra value SHALL be identical with and without the macro.

Verification
REQ-017 The bench SHALL cover the following directed scenarios:
- a=15, b=15, ld pulse then 4 edges -> ra=8'hE1, cnt=4, done=1; done=0 after edges 1-3.
- a=3, b=5 -> after step 1 ra=3, rb=6, ry=2; after step 4 ra=8'h0F, done=1.
- a=9, b=0 -> without macro, done after 4 edges with ra=0, cnt=4; with MUL_EARLY_EXIT_EN, done=1 after 1 edge with ra=0, cnt=0.
- a=7, b=6, 2 steps, then ld=1 with a=2, b=3 -> clean restart; final ra=6 after 4 more edges.
- a=15, b=9, rst=0 pulse between edges after step 2 -> all outputs 0 immediately; IDLE holds with ld=0.
- Completed 5x5 (ra=25), then 10 further edges with ld=0 and a, b toggling -> ra=25, done=1 unchanged.

Source files
------------

// File: rtl/mul.sv
// Registered 4x4 unsigned shift-and-add multiplier (IDLE/RUN/DONE).
// Optional macro MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module mul (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] ra,
    output logic [7:0] rb,
    output logic [3:0] ry,
    output logic [2:0] cnt,
    output logic       done
);

    localparam int unsigned OP_W   = 4;
    localparam int unsigned PROD_W = 2 * OP_W;
    localparam int unsigned CNT_W  = 3;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(OP_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PROD_W-1:0] ra_q, ra_d;
    logic [PROD_W-1:0] rb_q, rb_d;
    logic [OP_W-1:0]   ry_q, ry_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;

    // Next-state: load wins in every state; RUN performs one shift-and-add step per edge.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        ry_d    = ry_q;
        cnt_d   = cnt_q;
        done_d  = done_q;

        if (ld) begin
            state_d = RUN;
            ra_d    = '0;
            rb_d    = {OP_W'(0), a};
            ry_d    = b;
            cnt_d   = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
`ifdef MUL_EARLY_EXIT_EN
                    if (ry_q == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
`else
                    begin
`endif
                        if (ry_q[0]) begin
                            ra_d = ra_q + rb_q;
                        end
                        rb_d  = rb_q << 1;
                        ry_d  = ry_q >> 1;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_STEP) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            ry_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            ry_q    <= ry_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign ra   = ra_q;
    assign rb   = rb_q;
    assign ry   = ry_q;
    assign cnt  = cnt_q;
    assign done = done_q;

endmodule
